// File: rtl/mips_main_control_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables plus the ALUOp/Funct pair. Optional trap: CTRL_ILLEGAL_TRAP_EN.
module mips_main_control_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [5:0] Funct,
  output logic [3:0] state_out,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEX    = 4'd6,
    S_RTWB    = 4'd7,
    S_BEQ     = 4'd8,
    S_IEX     = 4'd9,
    S_IWB     = 4'd10,
    S_JUMP    = 4'd11,
    S_JR      = 4'd12,
    S_ILLEGAL = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  state_t state, next_state;
  logic   is_logic_imm;

  assign is_logic_imm = (opcode == OP_LUI) || (opcode == OP_ORI);

  always_ff @(posedge clk) begin
    if (reset) state <= state_t'(RESET_STATE);
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                       next_state = (funct == FN_JR) ? S_JR : S_RTEX;
          OP_LW, OP_SW:                   next_state = S_MEMADR;
          OP_BEQ:                         next_state = S_BEQ;
          OP_ADDI, OP_ADDIU, OP_LUI, OP_ORI: next_state = S_IEX;
          OP_J:                           next_state = S_JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:                        next_state = S_ILLEGAL;
`else
          default:                        next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: next_state = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  if (mem_ready) next_state = S_FETCH;
      S_RTEX:   next_state = S_RTWB;
      S_RTWB:   next_state = S_FETCH;
      S_BEQ:    next_state = S_FETCH;
      S_IEX:    next_state = S_IWB;
      S_IWB:    next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      S_JR:     next_state = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_ILLEGAL: next_state = S_ILLEGAL;
`endif
      default:  next_state = S_FETCH;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Set on entry so the flag is already visible during the first ILLEGAL cycle.
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (reset)                        illegal_q <= 1'b0;
    else if (next_state == S_ILLEGAL) illegal_q <= 1'b1;
  end
  assign illegal_op = illegal_q & ~reset;
`else
  assign illegal_op = 1'b0;
`endif

  // While reset is high every output is held at zero regardless of state.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    Funct       = 6'b000000;
    state_out   = 4'd0;
    if (!reset) begin
      state_out = state;
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_RTEX: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          Funct   = funct;
        end
        S_RTWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
          ALUOp    = 2'b10;
          Funct    = funct;
        end
        S_BEQ: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_IEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          if (is_logic_imm) begin
            ALUOp = 2'b11;
            Funct = opcode;
          end
        end
        S_IWB: begin
          RegWrite = 1'b1;
          if (is_logic_imm) begin
            ALUOp = 2'b11;
            Funct = opcode;
          end
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_JR: begin
          PCWrite  = 1'b1;
          PCSource = 2'b11;
          ALUOp    = 2'b10;
          Funct    = funct;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_main_control_fsm.sv
// Scoreboard bench for mips_main_control_fsm: driver pushes hand-built expected
// output vectors each cycle, a negedge monitor pops and compares.
module tb_mips_main_control_fsm;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [5:0] Funct;
  logic [3:0] state_out;
  logic       illegal_op;

  mips_main_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .Funct(Funct), .state_out(state_out), .illegal_op(illegal_op)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, en[9:0], ALUSrcB, PCSource, ALUOp, Funct, illegal_op}
  // en = {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,RegDst,ALUSrcA}
  localparam int W = 27;
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           passed = 0;

  logic [W-1:0] obs;
  assign obs = {state_out, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource, ALUOp, Funct, illegal_op};

  function automatic logic [W-1:0] o(input logic [3:0] st, input logic [9:0] en,
                                     input logic [1:0] asb, input logic [1:0] pcs,
                                     input logic [1:0] aop, input logic [5:0] fn,
                                     input logic ill);
    return {st, en, asb, pcs, aop, fn, ill};
  endfunction

  // hand-written per-state expectations
  localparam logic [9:0] EN_FETCH_RDY  = 10'b1001001000;
  localparam logic [9:0] EN_FETCH_WAIT = 10'b0001000000;
  localparam logic [9:0] EN_ALUA       = 10'b0000000001;
  localparam logic [9:0] EN_MEMRD      = 10'b0011000000;
  localparam logic [9:0] EN_MEMWB      = 10'b0000010100;
  localparam logic [9:0] EN_MEMWR      = 10'b0010100000;
  localparam logic [9:0] EN_RTWB       = 10'b0000000110;
  localparam logic [9:0] EN_BEQ        = 10'b0100000001;
  localparam logic [9:0] EN_IWB        = 10'b0000000100;
  localparam logic [9:0] EN_PCW        = 10'b1000000000;

  logic [W-1:0] e_fetch, e_fetch_wait, e_decode, e_zero;

  // driver
  task automatic step(input logic rst, input logic mr, input logic [W-1:0] e, input string nm);
    reset     = rst;
    mem_ready = mr;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (obs !== e)
        $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                 nm, obs[W-1 -: 4], obs, e[W-1 -: 4], e);
      else
        passed++;
    end
  end

  initial begin
    e_fetch      = o(4'd0, EN_FETCH_RDY,  2'b01, 2'b00, 2'b00, 6'd0, 1'b0);
    e_fetch_wait = o(4'd0, EN_FETCH_WAIT, 2'b01, 2'b00, 2'b00, 6'd0, 1'b0);
    e_decode     = o(4'd1, 10'd0,         2'b11, 2'b00, 2'b00, 6'd0, 1'b0);
    e_zero       = '0;

    reset = 1'b1; mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0;
    @(posedge clk); #1;
    step(1'b1, 1'b1, e_zero, "reset_outputs_zero");

    // ADDU
    opcode = 6'b000000; funct = 6'b100001;
    step(1'b0, 1'b1, e_fetch,  "addu_fetch");
    step(1'b0, 1'b1, e_decode, "addu_decode");
    step(1'b0, 1'b0, o(4'd6, EN_ALUA, 2'b00, 2'b00, 2'b10, 6'b100001, 1'b0), "addu_rtex");
    step(1'b0, 1'b1, o(4'd7, EN_RTWB, 2'b00, 2'b00, 2'b10, 6'b100001, 1'b0), "addu_rtwb");

    // LW with two wait cycles in MEMRD, plus one FETCH wait
    opcode = 6'b100011; funct = 6'b000000;
    step(1'b0, 1'b0, e_fetch_wait, "lw_fetch_wait");
    step(1'b0, 1'b1, e_fetch,  "lw_fetch");
    step(1'b0, 1'b0, e_decode, "lw_decode");
    step(1'b0, 1'b0, o(4'd2, EN_ALUA,  2'b10, 2'b00, 2'b00, 6'd0, 1'b0), "lw_memadr");
    step(1'b0, 1'b0, o(4'd3, EN_MEMRD, 2'b00, 2'b00, 2'b00, 6'd0, 1'b0), "lw_memrd_w1");
    step(1'b0, 1'b0, o(4'd3, EN_MEMRD, 2'b00, 2'b00, 2'b00, 6'd0, 1'b0), "lw_memrd_w2");
    step(1'b0, 1'b1, o(4'd3, EN_MEMRD, 2'b00, 2'b00, 2'b00, 6'd0, 1'b0), "lw_memrd_rdy");
    step(1'b0, 1'b0, o(4'd4, EN_MEMWB, 2'b00, 2'b00, 2'b00, 6'd0, 1'b0), "lw_memwb");

    // ORI
    opcode = 6'b001101; funct = 6'b111111;
    step(1'b0, 1'b1, e_fetch,  "ori_fetch");
    step(1'b0, 1'b1, e_decode, "ori_decode");
    step(1'b0, 1'b1, o(4'd9,  EN_ALUA, 2'b10, 2'b00, 2'b11, 6'b001101, 1'b0), "ori_iex");
    step(1'b0, 1'b1, o(4'd10, EN_IWB,  2'b00, 2'b00, 2'b11, 6'b001101, 1'b0), "ori_iwb");

    // ADDI: plain add, Funct stays zero
    opcode = 6'b001000; funct = 6'b100000;
    step(1'b0, 1'b1, e_fetch,  "addi_fetch");
    step(1'b0, 1'b1, e_decode, "addi_decode");
    step(1'b0, 1'b1, o(4'd9,  EN_ALUA, 2'b10, 2'b00, 2'b00, 6'd0, 1'b0), "addi_iex");
    step(1'b0, 1'b1, o(4'd10, EN_IWB,  2'b00, 2'b00, 2'b00, 6'd0, 1'b0), "addi_iwb");

    // BEQ
    opcode = 6'b000100; funct = 6'b000000;
    step(1'b0, 1'b1, e_fetch,  "beq_fetch");
    step(1'b0, 1'b1, e_decode, "beq_decode");
    step(1'b0, 1'b1, o(4'd8, EN_BEQ, 2'b00, 2'b01, 2'b01, 6'd0, 1'b0), "beq_exec");

    // JR
    opcode = 6'b000000; funct = 6'b001000;
    step(1'b0, 1'b1, e_fetch,  "jr_fetch");
    step(1'b0, 1'b1, e_decode, "jr_decode");
    step(1'b0, 1'b1, o(4'd12, EN_PCW, 2'b00, 2'b11, 2'b10, 6'b001000, 1'b0), "jr_exec");

    // J
    opcode = 6'b000010; funct = 6'b000000;
    step(1'b0, 1'b1, e_fetch,  "j_fetch");
    step(1'b0, 1'b1, e_decode, "j_decode");
    step(1'b0, 1'b1, o(4'd11, EN_PCW, 2'b00, 2'b10, 2'b00, 6'd0, 1'b0), "j_exec");

    // SW stalled in MEMWR, then reset mid-access
    opcode = 6'b101011;
    step(1'b0, 1'b1, e_fetch,  "sw_fetch");
    step(1'b0, 1'b1, e_decode, "sw_decode");
    step(1'b0, 1'b1, o(4'd2, EN_ALUA,  2'b10, 2'b00, 2'b00, 6'd0, 1'b0), "sw_memadr");
    step(1'b0, 1'b0, o(4'd5, EN_MEMWR, 2'b00, 2'b00, 2'b00, 6'd0, 1'b0), "sw_memwr_wait");
    step(1'b1, 1'b1, e_zero, "sw_reset_in_memwr");
    step(1'b0, 1'b1, e_fetch, "after_reset_fetch");

    // unknown opcode
    opcode = 6'b111111;
    step(1'b0, 1'b1, e_decode, "illop_decode");
`ifdef CTRL_ILLEGAL_TRAP_EN
    step(1'b0, 1'b1, o(4'd15, 10'd0, 2'b00, 2'b00, 2'b00, 6'd0, 1'b1), "illop_trap1");
    opcode = 6'b000000;
    step(1'b0, 1'b1, o(4'd15, 10'd0, 2'b00, 2'b00, 2'b00, 6'd0, 1'b1), "illop_trap2");
    step(1'b0, 1'b1, o(4'd15, 10'd0, 2'b00, 2'b00, 2'b00, 6'd0, 1'b1), "illop_trap3");
    step(1'b1, 1'b1, e_zero, "illop_reset");
    step(1'b0, 1'b1, e_fetch, "illop_after_reset");
`else
    step(1'b0, 1'b1, e_fetch, "illop_nop_fetch");
    opcode = 6'b000010;
    step(1'b0, 1'b1, e_decode, "illop_next_decode");
`endif

    // let the monitor drain, bounded
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mips_main_control_fsm.md
# mips_main_control_fsm

Multicycle main control state machine for the MIPS core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable. It also produces the `ALUOp` and `Funct` pair consumed directly by the downstream ALU control unit. One instruction is in flight at a time; memory accesses stall on a ready handshake.

## Interface
Parameters:
- `RESET_STATE`, 4'd0: state entered on reset (FETCH).

Ports:
- `clk`  in  1  single core clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  IR[31:26], stable from DECODE until next FETCH completes.
- `funct`  in  6  IR[5:0].
- `mem_ready`  in  1  memory completes current read/write this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA`  out  1 each  datapath enables/selects.
- `ALUSrcB`  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2.
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs (JR).
- `ALUOp`  out  2  to ALU control: 00 add, 01 sub, 10 R-type, 11 I-type logic.
- `Funct`  out  6  to ALU control Funct input.
- `state_out`  out  4  current state, debug.
- `illegal_op`  out  1  sticky illegal-opcode flag (see Configuration).

## Operation
- States: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 RTEX, 7 RTWB, 8 BEQ, 9 IEX, 10 IWB, 11 JUMP, 12 JR, 15 ILLEGAL.
- Unlisted outputs are 0 in each state. `Funct` is 000000 unless stated.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=00. IRWrite and PCWrite are asserted only in the cycle mem_ready=1. Holds until mem_ready, then goes to DECODE.
- DECODE: ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 000000 goes to RTEX, or to JR if funct=001000.
  - 100011 or 101011 goes to MEMADR.
  - 000100 goes to BEQ.
  - 001000, 001001, 001111 or 001101 goes to IEX.
  - 000010 goes to JUMP.
  - Any other opcode goes to FETCH, or to ILLEGAL when the trap is enabled.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready, then goes to FETCH.
- RTEX: ALUSrcA=1, ALUSrcB=00, ALUOp=10, Funct=funct. Goes to RTWB.
- RTWB: RegWrite=1, RegDst=1, with ALUOp=10 and Funct=funct held. Goes to FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- IEX: ALUSrcA=1, ALUSrcB=10.
  - ADDI/ADDIU: ALUOp=00.
  - LUI/ORI: ALUOp=11, Funct=opcode. The `LUI`/`ORI` defines equal 001111/001101.
  - Goes to IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0, with IEX ALUOp/Funct held. Goes to FETCH.
- JUMP: PCWrite=1, PCSource=10. Goes to FETCH.
- JR: PCWrite=1, PCSource=11, ALUOp=10, Funct=funct. Goes to FETCH.

## Timing
- Reset behaviour:
  - `reset` high at a rising edge sets state to FETCH from any state, including mid-MEMRD/MEMWR.
  - While `reset` is high, all outputs are forced to 0 and `state_out`=0. This includes MemRead, IRWrite and PCWrite.
  - `illegal_op` clears only on reset.
- State register updates on the rising edge. Outputs are combinational from state; IRWrite/PCWrite in FETCH also depend on mem_ready.
- Latency with zero-wait memory (mem_ready tied 1):

  | Instruction | Cycles |
  |---|---|
  | LW | 5 |
  | SW, R-type, ADDI/ADDIU/LUI/ORI | 4 |
  | BEQ, J, JR | 3 |

  Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- mem_ready is ignored in every non-memory state.
- At most one register write per instruction. MemWrite is never asserted together with RegWrite.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE goes to ILLEGAL.
  - ILLEGAL sets `illegal_op`=1 and holds all enables at 0.
  - ILLEGAL is left only by reset.
- `CTRL_ILLEGAL_TRAP_EN` undefined:
  - An unknown opcode returns to FETCH as a NOP.
  - ILLEGAL is unreachable.
  - `illegal_op` is tied 0.

## Test plan
- Reset, then mem_ready=1, opcode=000000, funct=100001 (ADDU):
  - States 0,1,6,7,0.
  - RTEX shows ALUOp=10, Funct=100001.
  - RTWB shows RegWrite=1, RegDst=1.
- LW (100011) with mem_ready low for 2 cycles in MEMRD:
  - States 0,1,2,3,3,3,4,0.
  - MEMWB shows RegWrite=1, MemtoReg=1.
- ORI (001101):
  - IEX shows ALUOp=11, Funct=001101, ALUSrcB=10.
  - Then IWB with RegWrite=1, RegDst=0.
- BEQ (000100): states 0,1,8,0, with PCWriteCond=1, ALUOp=01, PCSource=01 in BEQ.
- JR (opcode 000000, funct 001000): states 0,1,12,0, with PCWrite=1, PCSource=11 in JR.
- Reset asserted during MEMWR: next state is FETCH and all outputs are 0 during reset.
- Opcode 111111, trap enabled: goes to ILLEGAL, `illegal_op`=1, state held there until reset.
- Opcode 111111, trap disabled: returns to FETCH, `illegal_op`=0.
